// File: rtl/adau_cmd_arbiter.sv
// Arbitrates the ADAU control-port SPI master between the boot command sequencer
// and a CPU command FIFO, with a programmable idle gap after every accepted command.
module adau_cmd_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   init_command,
    input  logic                          init_valid,
    output logic                          init_ready,
    input  logic                          init_done,
    input  logic [31:0]                   cpu_command,
    input  logic                          cpu_write,
    output logic                          cpu_full,
    output logic [$clog2(FIFO_DEPTH):0]   cpu_level,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [31:0]                   spi_data,
    output logic                          spi_valid,
    input  logic                          spi_ready,
    output logic                          owner,
    output logic                          busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic [GW-1:0]   gap_cnt;
    logic            cpu_pending;
    logic            grant_init;
    logic            grant_cpu;
    logic            push_ok;
    logic            accept;

    // Boot source is exclusive before init_done; afterwards round-robin against the last owner.
    always_comb begin
        cpu_pending = (count != '0);
        grant_init  = (state_q == IDLE) && init_valid &&
                      (!init_done || !cpu_pending || owner);
        grant_cpu   = (state_q == IDLE) && init_done && cpu_pending && !grant_init;
        push_ok     = cpu_write && ((count != LW'(FIFO_DEPTH)) || grant_cpu);
        accept      = (state_q == ISSUE) && spi_ready;
    end

    assign init_ready = grant_init;
    assign cpu_full   = (count == LW'(FIFO_DEPTH));
    assign cpu_level  = count;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_init || grant_cpu) state_d = ISSUE;
            ISSUE:   if (spi_ready) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == GW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (accept) begin
            gap_cnt <= GW'(GAP_CYCLES);
        end else if (state_q == GAP) begin
            gap_cnt <= gap_cnt - GW'(1);
        end
    end

    // SPI-side command register and ownership record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_data  <= '0;
            spi_valid <= 1'b0;
            owner     <= 1'b0;
        end else if (grant_init || grant_cpu) begin
            spi_data  <= grant_cpu ? mem[rd_ptr] : init_command;
            spi_valid <= 1'b1;
            owner     <= grant_cpu;
        end else if (accept) begin
            spi_valid <= 1'b0;
        end
    end

    // Storage array carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= cpu_command;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)   wr_ptr <= AW'(wr_ptr + AW'(1));
            if (grant_cpu) rd_ptr <= AW'(rd_ptr + AW'(1));
            case ({push_ok, grant_cpu})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
            if (cpu_write && !push_ok) overflow <= 1'b1;
            else if (overflow_clr)     overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adau_cmd_arbiter.sv
// Directed and randomized bench for adau_cmd_arbiter against a transaction-level model.
module tb_adau_cmd_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned GAP   = 16;

    logic                       clk;
    logic                       reset;
    logic [31:0]                init_command;
    logic                       init_valid;
    logic                       init_ready;
    logic                       init_done;
    logic [31:0]                cpu_command;
    logic                       cpu_write;
    logic                       cpu_full;
    logic [$clog2(DEPTH):0]     cpu_level;
    logic                       overflow;
    logic                       overflow_clr;
    logic [31:0]                spi_data;
    logic                       spi_valid;
    logic                       spi_ready;
    logic                       owner;
    logic                       busy;

    adau_cmd_arbiter #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset),
        .init_command(init_command), .init_valid(init_valid), .init_ready(init_ready),
        .init_done(init_done),
        .cpu_command(cpu_command), .cpu_write(cpu_write), .cpu_full(cpu_full),
        .cpu_level(cpu_level), .overflow(overflow), .overflow_clr(overflow_clr),
        .spi_data(spi_data), .spi_valid(spi_valid), .spi_ready(spi_ready),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: pending FIFO words, the outstanding SPI command, and the cycle when granting reopens.
    logic [31:0] q[$];
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_owner;
    logic        m_ovf;
    int          cyc;
    int          idle_at;
    int          checks;
    int          passed;
    logic        last_gi;
    logic        last_gc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_owner = 1'b0;
        m_ovf   = 1'b0;
        idle_at = cyc;
    endtask

    task automatic step(input logic iv, input logic [31:0] ic, input logic idn,
                        input logic cw, input logic [31:0] cc, input logic sr,
                        input logic oc);
        logic idle, gi, gc, ovf_set;
        @(negedge clk);
        init_valid   = iv;
        init_command = ic;
        init_done    = idn;
        cpu_write    = cw;
        cpu_command  = cc;
        spi_ready    = sr;
        overflow_clr = oc;
        #1;
        idle = !m_valid && (cyc >= idle_at);
        gi   = idle && iv && (!idn || q.size() == 0 || m_owner);
        gc   = idle && idn && q.size() != 0 && !gi;
        chk("init_ready", 32'(init_ready), 32'(gi));
        chk("spi_valid",  32'(spi_valid),  32'(m_valid));
        chk("spi_data",   spi_data,        m_data);
        chk("owner",      32'(owner),      32'(m_owner));
        chk("busy",       32'(busy),       32'(!idle));
        chk("cpu_level",  32'(cpu_level),  32'(q.size()));
        chk("cpu_full",   32'(cpu_full),   32'(q.size() == DEPTH));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        @(posedge clk);
        last_gi = gi;
        last_gc = gc;
        ovf_set = 1'b0;
        if (m_valid && sr) begin
            m_valid = 1'b0;
            idle_at = cyc + 1 + GAP;
        end else if (gi) begin
            m_valid = 1'b1;
            m_data  = ic;
            m_owner = 1'b0;
        end else if (gc) begin
            m_valid = 1'b1;
            m_data  = q.pop_front();
            m_owner = 1'b1;
        end
        if (cw) begin
            if (q.size() < DEPTH) q.push_back(cc);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        cyc++;
    endtask

    task automatic idle_run(input int n, input logic idn);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, idn, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        logic prev_src;
        logic have_prev;
        clk = 1'b0; reset = 1'b1; cyc = 0; checks = 0; passed = 0;
        init_command = '0; init_valid = 1'b0; init_done = 1'b0;
        cpu_command = '0; cpu_write = 1'b0; spi_ready = 1'b0; overflow_clr = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_spi_valid", 32'(spi_valid), 32'd0);
        chk("rst_spi_data",  spi_data,       32'd0);
        chk("rst_owner",     32'(owner),     32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_level",     32'(cpu_level), 32'd0);
        chk("rst_full",      32'(cpu_full),  32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        reset = 1'b0;

        // Boot command issue and post-accept gap.
        step(1'b1, 32'h4000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        idle_run(20, 1'b0);

        // CPU words wait for init_done, then drain in order.
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00AA, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_00BB, 1'b1, 1'b0);
        idle_run(6, 1'b0);
        idle_run(45, 1'b1);

        // Both sources continuously pending: grants must alternate.
        have_prev = 1'b0;
        prev_src  = 1'b0;
        for (int i = 0; i < 120; i++) begin
            step(1'b1, $urandom, 1'b1, 1'(q.size() < DEPTH), $urandom, 1'b1, 1'b0);
            if (last_gi || last_gc) begin
                if (have_prev) chk("alternate", 32'(last_gc), 32'(!prev_src));
                prev_src  = last_gc;
                have_prev = 1'b1;
            end
        end
        idle_run(100, 1'b1);

        // Five pushes into a four-deep FIFO, then clear the sticky flag.
        for (int i = 0; i < 5; i++)
            step(1'b0, 32'h0, 1'b0, 1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 1'b0, 1'b1);
        idle_run(100, 1'b1);

        // Hold off spi_ready while a command is presented.
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        idle_run(20, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 15) != 0),
                 1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 19) == 0));
        idle_run(120, 1'b1);

        // Asynchronous reset while a CPU command is in ISSUE with three words queued.
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 1'b0, 1'b1, 32'h3000 + 32'(i), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(spi_valid), 32'd1);
        chk("pre_rst_level", 32'(cpu_level), 32'd3);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("async_spi_valid", 32'(spi_valid), 32'd0);
        chk("async_level",     32'(cpu_level), 32'd0);
        chk("async_busy",      32'(busy),      32'd0);
        chk("async_full",      32'(cpu_full),  32'd0);
        chk("async_data",      spi_data,       32'd0);
        model_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        cyc++;
        idle_at = cyc;
        step(1'b1, 32'h4000_0002, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        idle_run(20, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/adau_cmd_arbiter.md
Name: adau_cmd_arbiter

Overview:
- Shares the single ADAU control-port SPI master between two command sources:
  - the boot-time command list sequencer;
  - a CPU-side command FIFO written from the wishbone register logic.
- The boot sequencer has exclusive access until `init_done`. After that, the two sources are served round-robin.
- A programmable idle gap is enforced between consecutive SPI commands.
- Sits between adau_command_list / wishbone_bus_logic and adau_spi_master.

Parameters:
- FIFO_DEPTH, 4, CPU command FIFO depth in entries; power of 2, minimum 2.
- GAP_CYCLES, 16, idle clk cycles after each SPI accept before the next grant; 0 allowed.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- init_command  in  32  command word from the boot sequencer
- init_valid  in  1  boot command valid
- init_ready  out  1  boot command accepted this cycle when high together with init_valid
- init_done  in  1  boot sequence complete; level signal
- cpu_command  in  32  command word from the register interface
- cpu_write  in  1  single-cycle push strobe into the CPU FIFO
- cpu_full  out  1  FIFO full
- cpu_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky flag: a write was dropped
- overflow_clr  in  1  clears overflow
- spi_data  out  32  command word to the SPI master
- spi_valid  out  1  spi_data valid
- spi_ready  in  1  SPI master ready; a transfer occurs on a rising edge where spi_valid and spi_ready are both high
- owner  out  1  source of the current or last grant: 0 = init, 1 = cpu
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, immediate) forces the following; any in-flight command is abandoned and no partial SPI handshake is completed:
  - state = IDLE;
  - spi_valid = 0, spi_data = 0, owner = 0, busy = 0;
  - FIFO emptied: cpu_level = 0, cpu_full = 0;
  - overflow = 0, gap counter = 0.
- States: IDLE, ISSUE, GAP.
- init_ready is combinational: high exactly when state = IDLE and the grant selects init.
- Grant selection in IDLE:
  - If init_done = 0: only init is eligible. A pending FIFO entry waits.
  - If init_done = 1 and both sources are pending: the source not equal to owner wins (round-robin).
  - If only one source is pending: that source wins.
  - If neither is pending: stay in IDLE.
- IDLE -> ISSUE on a grant:
  - spi_data is registered with the winner's word;
  - spi_valid = 1 from the next cycle;
  - owner is updated;
  - an init grant consumes init_command through the init_valid/init_ready handshake; a cpu grant pops the FIFO head.
- In ISSUE, spi_data and spi_valid are held stable until spi_ready = 1. On that edge:
  - spi_valid = 0;
  - go to GAP with the counter loaded to GAP_CYCLES;
  - if GAP_CYCLES = 0, go directly to IDLE.
- In GAP, the counter decrements once per cycle. Transition to IDLE on the edge where counter = 1.
- Minimum spacing between accepts is 1 (IDLE) + 1 (ISSUE) + GAP_CYCLES cycles.
- FIFO:
  - First-word fall-through head; circular pointers that wrap modulo FIFO_DEPTH.
  - A push is accepted when cpu_level < FIFO_DEPTH, or when a pop occurs in the same cycle. Push and pop in the same cycle leave cpu_level unchanged.
  - A push that is not accepted sets overflow and leaves FIFO contents untouched.
  - cpu_full = (cpu_level == FIFO_DEPTH).
- overflow:
  - A set in the same cycle as overflow_clr wins: overflow ends high.
- init_done deasserting while in ISSUE or GAP does not abort the command. It affects the next grant only.
- Values present on init_command or cpu_command while not granted are ignored; nothing is registered.

Test Plan:
- Reset, then init_valid = 1 with init_command = 32'h4000_0001 and spi_ready = 1:
  - init_ready is high in cycle 0;
  - spi_valid = 1 with spi_data = 32'h4000_0001 in cycle 1;
  - spi_valid = 0 in cycle 2;
  - next grant is possible no earlier than cycle 2 + GAP_CYCLES.
- init_done = 0, push 2 CPU words (AA, BB):
  - no cpu grant occurs and cpu_level = 2;
  - after init_done rises, AA then BB issue in order, each separated by GAP_CYCLES;
  - final cpu_level = 0.
- init_done = 1, init and CPU both pending continuously:
  - grants alternate init, cpu, init, cpu;
  - owner toggles with each grant.
- Push 5 words with FIFO_DEPTH = 4 and spi_ready = 0:
  - cpu_full = 1 after the 4th push;
  - the 5th push sets overflow;
  - cpu_level stays 4;
  - overflow_clr clears overflow on the next cycle.
- spi_ready held 0 for 10 cycles during ISSUE:
  - spi_data and spi_valid stay stable for all 10 cycles;
  - a single accept follows when spi_ready rises.
- Assert reset while in ISSUE with 3 FIFO entries:
  - spi_valid = 0, cpu_level = 0 and busy = 0 immediately, without waiting for a clock edge.
